// File: rtl/fibonacci_dual_rate_if.sv
// Output bundle of the dual-rate Fibonacci generator.
// The generator drives the bundle (master); consumers only observe it (slave).
interface fibonacci_dual_rate_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] num;     // single-rate term F(k+1)
  logic [WIDTH-1:0] num_d;   // double-rate odd term F(2k+1)
  logic [WIDTH-1:0] num2_d;  // double-rate even term F(2k+2)

  modport master (output num, num_d, num2_d);
  modport slave  (input  num, num_d, num2_d);
endinterface

// File: rtl/fibonacci_dual_rate.sv
// Free-running Fibonacci source with two engines on one clock:
//   - single-rate engine: one term per clock on num
//   - double-rate engine: two consecutive terms per clock on num_d/num2_d
// Both restart from F(1)=F(2)=1 on reset, so the single-rate stream equals
// the double-rate pairs flattened in order. Arithmetic wraps mod 2^WIDTH.
module fibonacci_dual_rate #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,  // asynchronous, active-low
  fibonacci_dual_rate_if.master bus
);

  // Single-rate state: r_cur is the term on display, r_nxt the one after it.
  logic [WIDTH-1:0] r_cur;
  logic [WIDTH-1:0] r_nxt;

  // Double-rate state: a pair of consecutive terms (F(2k+1), F(2k+2)).
  logic [WIDTH-1:0] r_num_d;
  logic [WIDTH-1:0] r_num2_d;

  // Next-state sums; all truncated to WIDTH bits so overflow wraps silently.
  logic [WIDTH-1:0] w_cur_sum;
  logic [WIDTH-1:0] w_d_sum;
  logic [WIDTH-1:0] w_d2_sum;

  // F(n+2) = F(n) + F(n+1); for the pair, F(2k+3) = a + b and
  // F(2k+4) = F(2k+3) + b = a + 2b, reusing the first sum.
  assign w_cur_sum = r_cur + r_nxt;
  assign w_d_sum   = r_num_d + r_num2_d;
  assign w_d2_sum  = w_d_sum + r_num2_d;

  // Single-rate engine: shift the window one term per clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cur <= {{(WIDTH-1){1'b0}}, 1'b1};
      r_nxt <= {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r_cur <= r_nxt;
      r_nxt <= w_cur_sum;
    end
  end

  // Double-rate engine: jump the pair two terms ahead per clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_num_d  <= {{(WIDTH-1){1'b0}}, 1'b1};
      r_num2_d <= {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r_num_d  <= w_d_sum;
      r_num2_d <= w_d2_sum;
    end
  end

  // Outputs come straight from registers; no input reaches them combinationally.
  assign bus.num    = r_cur;
  assign bus.num_d  = r_num_d;
  assign bus.num2_d = r_num2_d;

endmodule

// File: tb/tb_fibonacci_dual_rate.sv
// Directed + randomized-reset bench for fibonacci_dual_rate.
// Expected terms come from a bench-side Fibonacci table indexed by edge count,
// queued per clock edge and popped when the outputs are sampled.
module tb_fibonacci_dual_rate;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fibonacci_dual_rate_if #(.WIDTH(WIDTH)) bus ();

  fibonacci_dual_rate #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [WIDTH-1:0] num;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] d2;
    int               edge_n;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] q_s[$];
  logic [WIDTH-1:0] q_d[$];
  logic [WIDTH-1:0] fib[0:127];
  int               lit_seq[10];
  int               n_cmp = 0;
  int               n_err = 0;
  int               edges = 0;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_num"},    bus.num,    16'd1);
    check({tag, "_num_d"},  bus.num_d,  16'd1);
    check({tag, "_num2_d"}, bus.num2_d, 16'd1);
  endtask

  // Expected outputs after 'edges' advancing edges since release.
  task automatic push_exp();
    exp_t e;
    e.num    = fib[edges + 1];
    e.d      = fib[2*edges + 1];
    e.d2     = fib[2*edges + 2];
    e.edge_n = edges;
    sb.push_back(e);
  endtask

  task automatic sample_and_check();
    exp_t e;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    $display("edge %0d: num=%0d num_d=%0d num2_d=%0d", e.edge_n,
             bus.num, bus.num_d, bus.num2_d);
    check("num",    bus.num,    e.num);
    check("num_d",  bus.num_d,  e.d);
    check("num2_d", bus.num2_d, e.d2);
    if (e.edge_n < 10) check("num_literal", bus.num, lit_seq[e.edge_n][WIDTH-1:0]);
    // Single-rate stream must match the flattened double-rate stream.
    q_s.push_back(bus.num);
    q_d.push_back(bus.num_d);
    q_d.push_back(bus.num2_d);
    while (q_s.size() > 0 && q_d.size() > 0) begin
      a = q_s.pop_front();
      b = q_d.pop_front();
      check("stream_equiv", a, b);
    end
  endtask

  task automatic step();
    @(posedge clk);
    edges++;
    push_exp();
    @(negedge clk);
    sample_and_check();
  endtask

  // Release between edges and check the reset state as sample 0 of the run.
  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    edges = 0;
    sb.delete();
    q_s.delete();
    q_d.delete();
    #1;
    push_exp();
    sample_and_check();
  endtask

  // Drop reset between edges; outputs must clear before any clock edge.
  task automatic async_reset(input int off);
    @(negedge clk);
    #(off);
    rst = 1'b0;
    #1;
    check_reset_vals("async_immediate");
    @(negedge clk);
    check_reset_vals("async_hold");
  endtask

  initial begin
    fib[0] = '0;
    fib[1] = 16'd1;
    fib[2] = 16'd1;
    for (int i = 3; i < 128; i++) fib[i] = fib[i-1] + fib[i-2];
    lit_seq = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55};

    // Reset held with the clock running: values stay at 1/1/1.
    repeat (3) begin
      @(negedge clk);
      check_reset_vals("reset_hold");
    end

    // Release and run past the 16-bit wrap point.
    release_reset();
    while (edges < 24) begin
      step();
      if (edges == 1) begin
        check("first_pair_d",  bus.num_d,  16'd2);
        check("first_pair_d2", bus.num2_d, 16'd3);
      end
      if (edges == 12) begin
        check("wrap_num_d",  bus.num_d,  16'd9489);
        check("wrap_num2_d", bus.num2_d, 16'd55857);
      end
      if (edges == 23) check("pre_wrap_num", bus.num, 16'd46368);
      if (edges == 24) check("wrap_num",     bus.num, 16'd9489);
    end

    // Asynchronous reset mid-run, then restart from term 1.
    async_reset(2);
    release_reset();
    repeat (10) step();

    // Randomized run lengths and reset pulse positions.
    for (int it = 0; it < 8; it++) begin
      int n;
      n = $urandom_range(3, 40);
      repeat (n) step();
      async_reset($urandom_range(1, 3));
      release_reset();
      repeat (4) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fibonacci_dual_rate.md
Name: fibonacci_dual_rate

Overview:
- Free-running Fibonacci sequence generator with two independent engines sharing one clock and reset.
- Single-rate engine: emits one term per clock on `num`.
- Double-rate engine: emits two consecutive terms per clock on `num_d` and `num2_d`.
- Used as a stream source and as a self-check pair: the single-rate stream must equal the double-rate pairs concatenated in order (`num_d` first, then `num2_d`).

Parameters:
- WIDTH, default 16: bit width of every term and output. All arithmetic is modulo 2^WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- num  output  WIDTH  single-rate term F(k+1) after k post-reset clock edges.
- num_d  output  WIDTH  double-rate odd term F(2k+1) after k post-reset clock edges.
- num2_d  output  WIDTH  double-rate even term F(2k+2) after k post-reset clock edges.

Behaviour:
- Sequence definition: F(1)=1, F(2)=1, F(n)=F(n-1)+F(n-2), truncated to WIDTH bits.
- All outputs are registered directly; no combinational path from any input to any output.
- Reset is asynchronous: outputs take reset values immediately on rst falling to 0, without waiting for a clock edge. They hold those values while rst=0.
- Reset values:
  - num = 1
  - num_d = 1, num2_d = 1
  - Internal single-rate state: cur = 1, nxt = 1.
- Single-rate update, each rising clk with rst=1:
  - cur <= nxt
  - nxt <= cur + nxt
  - num = cur
- Double-rate update, each rising clk with rst=1:
  - num_d <= num_d + num2_d
  - num2_d <= num_d + 2*num2_d
  - Every sum is truncated mod 2^WIDTH.
- Latency: the first clock edge after release advances both engines. Output values:
  - At reset: num=1; (num_d, num2_d)=(1,1).
  - Edge 1: num=1; (2,3).
  - Edge 2: num=2; (5,8).
  - Edge 3: num=3; (13,21).
- Invariant: at every edge count k, the single-rate value num after edge 2k equals num_d, and after edge 2k+1 equals num2_d.
- Overflow: silent wrap-around. There is no saturation and no overflow flag, and the sequence continues from the wrapped values.
- Reset mid-operation: both engines return to reset values immediately and restart from term 1 in lockstep.
- Reset release coinciding with a clock edge: the edge does not advance state. The first advance is on the next edge.
- No enable, no handshake; both engines advance on every clock edge while out of reset.

Test Plan:
- Hold rst=0, clock running -> num=1, num_d=1, num2_d=1 every cycle; values must not change.
- Release reset, sample 10 consecutive edges -> num = 1,1,2,3,5,8,13,21,34,55; (num_d, num2_d) over the first 5 edges = (2,3),(5,8),(13,21),(34,55),(89,144).
- Collect 10 single-rate samples starting at the reset state and 5 double-rate pairs starting at the reset state, pairs flattened -> the two streams are identical: 1,1,2,3,5,8,13,21,34,55.
- Wrap-around at WIDTH=16:
  - After 23 edges, num=46368.
  - After 24 edges, num=9489 (75025 mod 65536).
  - After 12 edges, num_d=9489 and num2_d=55857.
- Assert rst=0 asynchronously mid-run (between clock edges) -> outputs read 1/1/1 before the next clk edge; after release the sequence restarts from the beginning for both engines.
- Randomized reset pulses over a long run -> the single/double-rate equivalence invariant holds after every release.
